// File: rtl/tri_bus_mux_pkg.sv
// ---------------------------------------------------------------------------
// tri_bus_mux_pkg
// Shared types and helpers for the tri-state bus multiplexer.
//   state_t          : bus ownership FSM states (IDLE, DRIVE, TURN)
//   sel_width()      : width of the channel-select field for a channel count
//   turn_cnt_width() : width of the bus turnaround counter
// ---------------------------------------------------------------------------
package tri_bus_mux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    // Never narrower than one bit so that req_sel always exists as a port.
    function automatic int sel_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Holds the values 0..turn_cycles inclusive.
    function automatic int turn_cnt_width(input int turn_cycles);
        return $clog2(turn_cycles + 1);
    endfunction

endpackage

// File: rtl/tri_bus_mux_drv.sv
// ---------------------------------------------------------------------------
// tri_bus_mux_drv
// One channel's tri-state driver onto the shared bus: a WIDTH-wide array of
// bufif1 gates sharing a single enable.
// Ports:
//   data : channel data to place on the bus
//   en   : drive enable; bus bits float (high-Z) when low
//   out  : shared tri-state bus
// ---------------------------------------------------------------------------
module tri_bus_mux_drv #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    output tri   [WIDTH-1:0] out
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_buf
        bufif1 u_buf (out[gi], data[gi], en);
    end

endmodule

// File: rtl/tri_bus_mux.sv
// ---------------------------------------------------------------------------
// tri_bus_mux
// Hands a shared tri-state bus to one of CHANNELS input channels at a time,
// inserting TURN_CYCLES all-off cycles whenever ownership changes so that two
// drivers never overlap.
// Ports:
//   clock        : sole clock, rising edge
//   reset_n      : asynchronous active-low reset
//   in_data      : channel k data in bits [k*WIDTH +: WIDTH]
//   req_sel      : requested driving channel
//   req_valid    : select request present
//   req_ready    : request accepted when req_valid && req_ready at an edge
//   bus_release  : single-cycle pulse that parks the bus (all drivers off)
//   out          : shared tri-state bus, high-Z when nobody drives
//   active_sel   : channel currently driving, 0 when none
//   driving      : high while exactly one channel drives out
//   sel_err      : one-cycle pulse after an accepted out-of-range/X/Z select
//   switch_cnt   : (only with TRI_BUS_MUX_SWITCH_CNT_EN defined) saturating
//                  count of TURN->DRIVE hand-overs
// Configuration macro: TRI_BUS_MUX_SWITCH_CNT_EN adds the switch_cnt output.
// ---------------------------------------------------------------------------
module tri_bus_mux
    import tri_bus_mux_pkg::*;
#(
    parameter  int WIDTH       = 8,
    parameter  int CHANNELS    = 4,
    parameter  int TURN_CYCLES = 1,
    localparam int SELW        = sel_width(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]           req_sel,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      bus_release,
    output tri   [WIDTH-1:0]          out,
    output logic [SELW-1:0]           active_sel,
    output logic                      driving,
    output logic                      sel_err
`ifdef TRI_BUS_MUX_SWITCH_CNT_EN
    ,
    output logic [15:0]               switch_cnt
`endif
);

    localparam int             CNTW      = turn_cnt_width(TURN_CYCLES);
    localparam logic [CNTW-1:0] TURN_LOAD = CNTW'(TURN_CYCLES);
    localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);

    state_t            state_reg, state_next;
    logic [SELW-1:0]   active_reg, active_next;
    logic [SELW-1:0]   pending_reg, pending_next;
    logic              pending_valid_reg, pending_valid_next;
    logic [CNTW-1:0]   cnt_reg, cnt_next;
    logic              sel_err_reg, sel_err_next;

    logic              accept;
    logic              sel_bad;
    logic              turn_done;
    logic [CHANNELS-1:0] en;

    // An unknown select only exists in simulation; in hardware the
    // $isunknown term folds to 0 and only the range check remains.
    assign sel_bad   = $isunknown(req_sel) || (int'(req_sel) >= CHANNELS);
    assign accept    = req_valid && req_ready;
    assign turn_done = (cnt_reg == CNT_ONE);

    always_comb begin
        req_ready = 1'b0;
        case (state_reg)
            IDLE:    req_ready = 1'b1;
            DRIVE:   req_ready = !bus_release;
            default: req_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_next         = state_reg;
        active_next        = active_reg;
        pending_next       = pending_reg;
        pending_valid_next = pending_valid_reg;
        cnt_next           = cnt_reg;
        sel_err_next       = accept && sel_bad;

        case (state_reg)
            IDLE: begin
                if (accept && !sel_bad) begin
                    state_next  = DRIVE;
                    active_next = req_sel;
                end
            end
            DRIVE: begin
                if (bus_release) begin
                    // Park: turnaround with nobody queued behind it.
                    state_next         = TURN;
                    active_next        = '0;
                    pending_next       = '0;
                    pending_valid_next = 1'b0;
                    cnt_next           = TURN_LOAD;
                end else if (accept && !sel_bad && (req_sel != active_reg)) begin
                    state_next         = TURN;
                    active_next        = '0;
                    pending_next       = req_sel;
                    pending_valid_next = 1'b1;
                    cnt_next           = TURN_LOAD;
                end
            end
            TURN: begin
                if (turn_done) begin
                    cnt_next = '0;
                    if (pending_valid_reg) begin
                        state_next         = DRIVE;
                        active_next        = pending_reg;
                        pending_next       = '0;
                        pending_valid_next = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            default: begin
                state_next         = IDLE;
                active_next        = '0;
                pending_next       = '0;
                pending_valid_next = 1'b0;
                cnt_next           = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= IDLE;
            active_reg        <= '0;
            pending_reg       <= '0;
            pending_valid_reg <= 1'b0;
            cnt_reg           <= '0;
            sel_err_reg       <= 1'b0;
        end else begin
            state_reg         <= state_next;
            active_reg        <= active_next;
            pending_reg       <= pending_next;
            pending_valid_reg <= pending_valid_next;
            cnt_reg           <= cnt_next;
            sel_err_reg       <= sel_err_next;
        end
    end

    assign active_sel = active_reg;
    assign driving    = (state_reg == DRIVE);
    assign sel_err    = sel_err_reg;

    // Enables come only from registered state, so a single active_reg value
    // can never light two drivers, and reset kills them without a clock.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        assign en[gi] = (state_reg == DRIVE) && (active_reg == SELW'(gi));

        tri_bus_mux_drv #(
            .WIDTH (WIDTH)
        ) u_drv (
            .data (in_data[gi*WIDTH +: WIDTH]),
            .en   (en[gi]),
            .out  (out)
        );
    end

`ifdef TRI_BUS_MUX_SWITCH_CNT_EN
    logic [15:0] switch_cnt_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            switch_cnt_reg <= '0;
        end else if ((state_reg == TURN) && turn_done && pending_valid_reg
                     && (switch_cnt_reg != 16'hFFFF)) begin
            switch_cnt_reg <= switch_cnt_reg + 16'd1;
        end
    end

    assign switch_cnt = switch_cnt_reg;
`endif

endmodule

// File: tb/tb_tri_bus_mux.sv
// ---------------------------------------------------------------------------
// tb_tri_bus_mux
// Self-checking bench for tri_bus_mux (WIDTH=8, CHANNELS=3, TURN_CYCLES=3).
// Each row of stimulus pushes its expected response to a queue; the response
// is popped and compared after the clock edge. A monitor checks every cycle
// that at most one channel enable is high.
// ---------------------------------------------------------------------------
module tb_tri_bus_mux;

    localparam int WIDTH       = 8;
    localparam int CHANNELS    = 3;
    localparam int TURN_CYCLES = 3;
    localparam int SELW        = 2;

    localparam logic [7:0] D0 = 8'h11;
    localparam logic [7:0] D1 = 8'h3C;
    localparam logic [7:0] D2 = 8'hA5;

    logic                      clock = 1'b0;
    logic                      reset_n;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [SELW-1:0]           req_sel;
    logic                      req_valid;
    logic                      req_ready;
    logic                      bus_release;
    tri   [WIDTH-1:0]          out;
    logic [SELW-1:0]           active_sel;
    logic                      driving;
    logic                      sel_err;
`ifdef TRI_BUS_MUX_SWITCH_CNT_EN
    logic [15:0]               switch_cnt;
`endif

    int checks = 0;
    int errors = 0;

    wire out_hiz = (out === 8'bzzzzzzzz);

    tri_bus_mux #(
        .WIDTH       (WIDTH),
        .CHANNELS    (CHANNELS),
        .TURN_CYCLES (TURN_CYCLES)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_data     (in_data),
        .req_sel     (req_sel),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .bus_release (bus_release),
        .out         (out),
        .active_sel  (active_sel),
        .driving     (driving),
        .sel_err     (sel_err)
`ifdef TRI_BUS_MUX_SWITCH_CNT_EN
        ,
        .switch_cnt  (switch_cnt)
`endif
    );

    always #5 clock = ~clock;

    // rst: pulse reset low during the low phase before this row's edge
    typedef struct {
        string      name;
        logic       rst;
        logic       v;
        logic [1:0] s;
        logic       r;
        logic       rdy;  // req_ready expected just before the edge
        logic [12:0] obs; // {hiz, data, driving, active_sel, sel_err} after the edge
    } row_t;

    row_t exp_q[$];

    function automatic logic [12:0] mk(input logic hiz, input logic [7:0] d,
                                       input logic drv, input logic [1:0] act,
                                       input logic err);
        return {hiz, d, drv, act, err};
    endfunction

    function automatic row_t mkrow(input string n, input logic rst, input logic v,
                                   input logic [1:0] s, input logic r,
                                   input logic rdy, input logic [12:0] o);
        row_t t;
        t.name = n; t.rst = rst; t.v = v; t.s = s; t.r = r; t.rdy = rdy; t.obs = o;
        return t;
    endfunction

    function automatic logic [12:0] observe();
        return {out_hiz, (out_hiz ? 8'h00 : out), driving, active_sel, sel_err};
    endfunction

    // Contention monitor: never two enables, enables agree with driving,
    // and a driven bus never resolves to X.
    always @(negedge clock) begin
        checks++;
        if (($countones(dut.en) > 1) || ($countones(dut.en) != int'(driving))
            || (!out_hiz && $isunknown(out))) begin
            errors++;
            $display("FAIL contention en=%b driving=%b out=%h (want <=1 enable matching driving)",
                     dut.en, driving, out);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clock);
        req_valid = 1'b0; req_sel = '0; bus_release = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        row_t e;
        reset_n = 1'b0; req_valid = 1'b0; req_sel = '0; bus_release = 1'b0;
        in_data = {D2, D1, D0};
        repeat (2) @(posedge clock);
        #1;
        exp_q.push_back(mkrow("reset_state", 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, mk(1, 8'h00, 0, 2'd0, 0)));
        e = exp_q.pop_front();
        checks++;
        if (req_ready !== e.rdy) begin errors++; $display("FAIL %s req_ready got %b want %b", e.name, req_ready, e.rdy); end
        checks++;
        if (observe() !== e.obs) begin errors++; $display("FAIL %s obs got %h want %h", e.name, observe(), e.obs); end
`ifdef TRI_BUS_MUX_SWITCH_CNT_EN
        checks++;
        if (switch_cnt !== 16'd0) begin errors++; $display("FAIL reset_switch_cnt got %0d want 0", switch_cnt); end
`endif
        $display("txn %s ready=%b obs=%h", e.name, req_ready, observe());
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_select();
        row_t rows[$];
        row_t e;
        logic pre;
        rows.push_back(mkrow("sel_ch2",  0, 1, 2'd2, 0, 1, mk(0, D2, 1, 2'd2, 0)));
        rows.push_back(mkrow("hold_ch2", 0, 0, 2'd0, 0, 1, mk(0, D2, 1, 2'd2, 0)));
        rows.push_back(mkrow("same_ch2", 0, 1, 2'd2, 0, 1, mk(0, D2, 1, 2'd2, 0)));
        foreach (rows[i]) begin
            @(negedge clock);
            if (rows[i].rst) begin reset_n = 1'b0; #1 reset_n = 1'b1; end
            req_valid = rows[i].v; req_sel = rows[i].s; bus_release = rows[i].r;
            exp_q.push_back(rows[i]);
            #1 pre = req_ready;
            @(posedge clock); #1;
            e = exp_q.pop_front();
            checks++;
            if (pre !== e.rdy) begin errors++; $display("FAIL %s req_ready got %b want %b", e.name, pre, e.rdy); end
            checks++;
            if (observe() !== e.obs) begin errors++; $display("FAIL %s obs got %h want %h", e.name, observe(), e.obs); end
            $display("txn %s v=%b sel=%b rel=%b ready=%b obs=%h", e.name, e.v, e.s, e.r, pre, observe());
        end
        // Data path is combinational while driving: a change shows up without an edge.
        in_data[2*WIDTH +: WIDTH] = 8'h5A;
        exp_q.push_back(mkrow("comb_data", 0, 0, 2'd0, 0, 1, mk(0, 8'h5A, 1, 2'd2, 0)));
        #1;
        e = exp_q.pop_front();
        checks++;
        if (observe() !== e.obs) begin errors++; $display("FAIL %s obs got %h want %h", e.name, observe(), e.obs); end
        $display("txn %s obs=%h", e.name, observe());
        in_data[2*WIDTH +: WIDTH] = D2;
        #1;
    endtask

    task automatic test_switch();
        row_t rows[$];
        row_t e;
        logic pre;
        rows.push_back(mkrow("sw_to_ch1",    0, 1, 2'd1, 0, 1, mk(1, 8'h00, 0, 2'd0, 0)));
        rows.push_back(mkrow("turn_req_ign", 0, 1, 2'd0, 0, 0, mk(1, 8'h00, 0, 2'd0, 0)));
        rows.push_back(mkrow("turn_rel_ign", 0, 0, 2'd0, 1, 0, mk(1, 8'h00, 0, 2'd0, 0)));
        rows.push_back(mkrow("drive_ch1",    0, 0, 2'd0, 0, 0, mk(0, D1, 1, 2'd1, 0)));
        rows.push_back(mkrow("hold_ch1",     0, 0, 2'd0, 0, 1, mk(0, D1, 1, 2'd1, 0)));
        foreach (rows[i]) begin
            @(negedge clock);
            if (rows[i].rst) begin reset_n = 1'b0; #1 reset_n = 1'b1; end
            req_valid = rows[i].v; req_sel = rows[i].s; bus_release = rows[i].r;
            exp_q.push_back(rows[i]);
            #1 pre = req_ready;
            @(posedge clock); #1;
            e = exp_q.pop_front();
            checks++;
            if (pre !== e.rdy) begin errors++; $display("FAIL %s req_ready got %b want %b", e.name, pre, e.rdy); end
            checks++;
            if (observe() !== e.obs) begin errors++; $display("FAIL %s obs got %h want %h", e.name, observe(), e.obs); end
            $display("txn %s v=%b sel=%b rel=%b ready=%b obs=%h", e.name, e.v, e.s, e.r, pre, observe());
        end
`ifdef TRI_BUS_MUX_SWITCH_CNT_EN
        checks++;
        if (switch_cnt !== 16'd1) begin errors++; $display("FAIL switch_cnt got %0d want 1", switch_cnt); end
`endif
    endtask

    task automatic test_release();
        row_t rows[$];
        row_t e;
        logic pre;
        rows.push_back(mkrow("rel_wins",  0, 1, 2'd0, 1, 0, mk(1, 8'h00, 0, 2'd0, 0)));
        rows.push_back(mkrow("turn_2",    0, 0, 2'd0, 0, 0, mk(1, 8'h00, 0, 2'd0, 0)));
        rows.push_back(mkrow("turn_3",    0, 1, 2'd2, 0, 0, mk(1, 8'h00, 0, 2'd0, 0)));
        rows.push_back(mkrow("to_idle",   0, 0, 2'd0, 0, 0, mk(1, 8'h00, 0, 2'd0, 0)));
        rows.push_back(mkrow("idle_rel",  0, 0, 2'd0, 1, 1, mk(1, 8'h00, 0, 2'd0, 0)));
        rows.push_back(mkrow("idle_sel1", 0, 1, 2'd1, 1, 1, mk(0, D1, 1, 2'd1, 0)));
        foreach (rows[i]) begin
            @(negedge clock);
            if (rows[i].rst) begin reset_n = 1'b0; #1 reset_n = 1'b1; end
            req_valid = rows[i].v; req_sel = rows[i].s; bus_release = rows[i].r;
            exp_q.push_back(rows[i]);
            #1 pre = req_ready;
            @(posedge clock); #1;
            e = exp_q.pop_front();
            checks++;
            if (pre !== e.rdy) begin errors++; $display("FAIL %s req_ready got %b want %b", e.name, pre, e.rdy); end
            checks++;
            if (observe() !== e.obs) begin errors++; $display("FAIL %s obs got %h want %h", e.name, observe(), e.obs); end
            $display("txn %s v=%b sel=%b rel=%b ready=%b obs=%h", e.name, e.v, e.s, e.r, pre, observe());
        end
`ifdef TRI_BUS_MUX_SWITCH_CNT_EN
        checks++;
        if (switch_cnt !== 16'd1) begin errors++; $display("FAIL switch_cnt_after_release got %0d want 1", switch_cnt); end
`endif
    endtask

    task automatic test_sel_err();
        row_t rows[$];
        row_t e;
        logic pre;
        logic [1:0] xv;
        logic bad;
        logic [12:0] xexp;
        rows.push_back(mkrow("sel_ch2",    1, 1, 2'd2, 0, 1, mk(0, D2, 1, 2'd2, 0)));
        rows.push_back(mkrow("oor_3",      0, 1, 2'd3, 0, 1, mk(0, D2, 1, 2'd2, 1)));
        rows.push_back(mkrow("err_clears", 0, 0, 2'd0, 0, 1, mk(0, D2, 1, 2'd2, 0)));
        rows.push_back(mkrow("idle_oor",   1, 1, 2'd3, 0, 1, mk(1, 8'h00, 0, 2'd0, 1)));
        rows.push_back(mkrow("idle_quiet", 0, 0, 2'd0, 0, 1, mk(1, 8'h00, 0, 2'd0, 0)));
        for (int k = 0; k < 2; k++) begin
            xv = (k == 0) ? 2'bxx : 2'bzz;
            // A two-state simulator turns X/Z into some plain value; derive
            // the expectation from whatever value the select actually holds.
            bad = $isunknown(xv) || (int'(xv) >= CHANNELS);
            if (bad)             xexp = mk(0, D0, 1, 2'd0, 1);
            else if (xv == 2'd0) xexp = mk(0, D0, 1, 2'd0, 0);
            else                 xexp = mk(1, 8'h00, 0, 2'd0, 0);
            rows.push_back(mkrow("sel_ch0", 1, 1, 2'd0, 0, 1, mk(0, D0, 1, 2'd0, 0)));
            rows.push_back(mkrow((k == 0) ? "sel_x" : "sel_z", 0, 1, xv, 0, 1, xexp));
        end
        foreach (rows[i]) begin
            @(negedge clock);
            if (rows[i].rst) begin reset_n = 1'b0; #1 reset_n = 1'b1; end
            req_valid = rows[i].v; req_sel = rows[i].s; bus_release = rows[i].r;
            exp_q.push_back(rows[i]);
            #1 pre = req_ready;
            @(posedge clock); #1;
            e = exp_q.pop_front();
            checks++;
            if (pre !== e.rdy) begin errors++; $display("FAIL %s req_ready got %b want %b", e.name, pre, e.rdy); end
            checks++;
            if (observe() !== e.obs) begin errors++; $display("FAIL %s obs got %h want %h", e.name, observe(), e.obs); end
            $display("txn %s v=%b sel=%b rel=%b ready=%b obs=%h", e.name, e.v, e.s, e.r, pre, observe());
        end
    endtask

    task automatic test_async_reset();
        row_t rows[$];
        row_t e;
        logic pre;
        rows.push_back(mkrow("sel_ch2", 1, 1, 2'd2, 0, 1, mk(0, D2, 1, 2'd2, 0)));
        rows.push_back(mkrow("sw_ch0",  0, 1, 2'd0, 0, 1, mk(1, 8'h00, 0, 2'd0, 0)));
        foreach (rows[i]) begin
            @(negedge clock);
            if (rows[i].rst) begin reset_n = 1'b0; #1 reset_n = 1'b1; end
            req_valid = rows[i].v; req_sel = rows[i].s; bus_release = rows[i].r;
            exp_q.push_back(rows[i]);
            #1 pre = req_ready;
            @(posedge clock); #1;
            e = exp_q.pop_front();
            checks++;
            if (pre !== e.rdy) begin errors++; $display("FAIL %s req_ready got %b want %b", e.name, pre, e.rdy); end
            checks++;
            if (observe() !== e.obs) begin errors++; $display("FAIL %s obs got %h want %h", e.name, observe(), e.obs); end
            $display("txn %s v=%b sel=%b rel=%b ready=%b obs=%h", e.name, e.v, e.s, e.r, pre, observe());
        end

        // Mid-TURN reset: outputs must go to reset values before any edge.
        @(negedge clock);
        req_valid = 1'b0;
        #2 reset_n = 1'b0;
        exp_q.push_back(mkrow("rst_mid_turn", 1, 0, 2'd0, 0, 1, mk(1, 8'h00, 0, 2'd0, 0)));
        #1;
        e = exp_q.pop_front();
        checks++;
        if (req_ready !== e.rdy) begin errors++; $display("FAIL %s req_ready got %b want %b", e.name, req_ready, e.rdy); end
        checks++;
        if (observe() !== e.obs) begin errors++; $display("FAIL %s obs got %h want %h", e.name, observe(), e.obs); end
        $display("txn %s ready=%b obs=%h", e.name, req_ready, observe());
`ifdef TRI_BUS_MUX_SWITCH_CNT_EN
        checks++;
        if (switch_cnt !== 16'd0) begin errors++; $display("FAIL rst_switch_cnt got %0d want 0", switch_cnt); end
`endif

        // First edge after release behaves as IDLE; the stale pending ch0 is gone.
        @(negedge clock);
        reset_n = 1'b1; req_valid = 1'b1; req_sel = 2'd1;
        exp_q.push_back(mkrow("post_rst_sel1", 0, 1, 2'd1, 0, 1, mk(0, D1, 1, 2'd1, 0)));
        @(posedge clock); #1;
        e = exp_q.pop_front();
        checks++;
        if (observe() !== e.obs) begin errors++; $display("FAIL %s obs got %h want %h", e.name, observe(), e.obs); end
        $display("txn %s obs=%h", e.name, observe());

        // Mid-DRIVE reset.
        @(negedge clock);
        req_valid = 1'b0;
        #2 reset_n = 1'b0;
        exp_q.push_back(mkrow("rst_mid_drive", 1, 0, 2'd0, 0, 1, mk(1, 8'h00, 0, 2'd0, 0)));
        #1;
        e = exp_q.pop_front();
        checks++;
        if (req_ready !== e.rdy) begin errors++; $display("FAIL %s req_ready got %b want %b", e.name, req_ready, e.rdy); end
        checks++;
        if (observe() !== e.obs) begin errors++; $display("FAIL %s obs got %h want %h", e.name, observe(), e.obs); end
        $display("txn %s ready=%b obs=%h", e.name, req_ready, observe());

        @(negedge clock);
        reset_n = 1'b1;
        exp_q.push_back(mkrow("idle_after_rst", 0, 0, 2'd0, 0, 1, mk(1, 8'h00, 0, 2'd0, 0)));
        repeat (2) @(posedge clock);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (observe() !== e.obs) begin errors++; $display("FAIL %s obs got %h want %h", e.name, observe(), e.obs); end
        $display("txn %s obs=%h", e.name, observe());
    endtask

    initial begin
        test_reset();
        test_select();
        test_switch();
        test_release();
        test_sel_err();
        test_async_reset();
        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
